spmv_csr_fetch: RTL and testbench

- Upstream feeder for the SpMV compute core.
- Loads the CSR row pointer array, then streams (matrix value, x[col]) pairs into the core on its LOAD cycles, and drives count/row_ptr.
- Restarts the core after every 16-nonzero batch until all nonzeros are consumed.
- Reads two synchronous single-port memories: a CSR memory (row_ptr and nonzero records) and an x-vector memory.

---
 rtl/spmv_csr_fetch_pkg.sv | 39 +++
 rtl/spmv_rowptr_loader.sv | 66 ++++++
 rtl/spmv_csr_fetch.sv | 228 ++++++++++++++++++++++
 tb/tb_spmv_csr_fetch.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spmv_csr_fetch_pkg.sv
// Shared encodings for the SpMV CSR fetch front-end: core states, batch sizes,
// fetch FSM states and nonzero record field layout.
package spmv_pkg;

  localparam logic [2:0] CORE_IDLE  = 3'd0;
  localparam logic [2:0] CORE_LOAD  = 3'd1;
  localparam logic [2:0] CORE_MUL   = 3'd2;
  localparam logic [2:0] CORE_ADD   = 3'd3;
  localparam logic [2:0] CORE_WRITE = 3'd4;

  localparam int BATCH_NNZ = 16;
  localparam int ROWS      = 16;
  localparam int ROWPTR_N  = 17;

  typedef logic [2:0] fetch_state_t;
  localparam fetch_state_t ST_IDLE    = 3'd0;
  localparam fetch_state_t ST_PTR     = 3'd1;
  localparam fetch_state_t ST_PRE_NZ  = 3'd2;
  localparam fetch_state_t ST_PRE_X   = 3'd3;
  localparam fetch_state_t ST_PRE_CAP = 3'd4;
  localparam fetch_state_t ST_KICK    = 3'd5;
  localparam fetch_state_t ST_RUN     = 3'd6;
  localparam fetch_state_t ST_DONE    = 3'd7;

  localparam int REC_W       = 24;
  localparam int REC_VAL_LSB = 0;
  localparam int REC_VAL_W   = 16;
  localparam int REC_COL_LSB = 16;
  localparam int REC_COL_W   = 8;

  function automatic logic [REC_VAL_W-1:0] rec_val(input logic [REC_W-1:0] rec);
    return rec[REC_VAL_LSB +: REC_VAL_W];
  endfunction

  function automatic logic [REC_COL_W-1:0] rec_col(input logic [REC_W-1:0] rec);
    return rec[REC_COL_LSB +: REC_COL_W];
  endfunction

endpackage

// File: rtl/spmv_rowptr_loader.sv
// Issues the 17 row_ptr reads and shifts each returned byte into its slot.
// With SPMV_FETCH_BOUNDS_EN it also flags a non-monotonic row_ptr word.
module spmv_rowptr_loader
  import spmv_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int ROWPTR_BASE = 0
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic [7:0]              rdata_i,
  output logic                    rd_en_o,
  output logic [ADDR_W-1:0]       rd_addr_o,
  output logic                    last_o,
  output logic [8*ROWPTR_N-1:0]   row_ptr_o
`ifdef SPMV_FETCH_BOUNDS_EN
  ,
  output logic                    mono_err_o
`endif
);

  logic                  issue_q;
  logic [4:0]            rd_idx_q;
  logic                  cap_vld_q;
  logic [4:0]            cap_idx_q;
  logic [8*ROWPTR_N-1:0] row_ptr_q;

  // Read index counter and one-cycle-delayed capture into the row_ptr vector
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      issue_q   <= 1'b0;
      rd_idx_q  <= 5'd0;
      cap_vld_q <= 1'b0;
      cap_idx_q <= 5'd0;
      row_ptr_q <= {(8*ROWPTR_N){1'b0}};
    end else if (abort_i) begin
      issue_q   <= 1'b0;
      cap_vld_q <= 1'b0;
    end else begin
      if (start_i) begin
        issue_q   <= 1'b1;
        rd_idx_q  <= 5'd0;
        row_ptr_q <= {(8*ROWPTR_N){1'b0}};
      end else if (issue_q) begin
        if (rd_idx_q == 5'(ROWPTR_N - 1)) issue_q <= 1'b0;
        else                              rd_idx_q <= rd_idx_q + 5'd1;
      end
      cap_vld_q <= issue_q;
      cap_idx_q <= rd_idx_q;
      if (cap_vld_q) row_ptr_q[{cap_idx_q, 3'b000} +: 8] <= rdata_i;
    end
  end

  assign rd_en_o   = issue_q;
  assign rd_addr_o = issue_q ? (ADDR_W'(ROWPTR_BASE) + ADDR_W'(rd_idx_q)) : {ADDR_W{1'b0}};
  assign last_o    = cap_vld_q && (cap_idx_q == 5'(ROWPTR_N - 1));
  assign row_ptr_o = row_ptr_q;

`ifdef SPMV_FETCH_BOUNDS_EN
  assign mono_err_o = cap_vld_q && (cap_idx_q != 5'd0) &&
                      (rdata_i < row_ptr_q[{cap_idx_q - 5'd1, 3'b000} +: 8]);
`endif

endmodule

// File: rtl/spmv_csr_fetch.sv
// CSR fetch front-end for the SpMV core: loads row_ptr, prefetches one nonzero
// ahead of the core cadence and restarts the core per batch. Optional bounds
// checking and the o_err port are enabled with SPMV_FETCH_BOUNDS_EN.
module spmv_csr_fetch
  import spmv_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int ROWPTR_BASE = 0,
  parameter int NZ_BASE     = 32,
  parameter int XADDR_W     = 4
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_start,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_csr_en,
  output logic [ADDR_W-1:0]  o_csr_addr,
  input  logic [23:0]        i_csr_rdata,
  output logic               o_x_en,
  output logic [XADDR_W-1:0] o_x_addr,
  input  logic [15:0]        i_x_rdata,
  input  logic [2:0]         i_core_state,
  output logic               o_core_start,
  output logic [15:0]        o_read_data_A,
  output logic [15:0]        o_read_data_B,
  output logic [7:0]         o_count,
  output logic [135:0]       o_row_ptr
`ifdef SPMV_FETCH_BOUNDS_EN
  ,
  output logic               o_err
`endif
);

  fetch_state_t state_q, state_d;
  logic [7:0]   count_q, count_d;
  logic [15:0]  stage_a_q, stage_a_d, stage_b_q, stage_b_d, stage_a_nxt_q, stage_a_nxt_d;
  logic         seen_core_q, seen_core_d;
  logic         busy_q, done_q;
  logic         ldr_start_s, ldr_en_s, ldr_last_s, bound_err_s, pf_s, x_rd_s;
  logic [ADDR_W-1:0] ldr_addr_s;
  logic [135:0] row_ptr_s;
  logic [7:0]   nnz_s, rec_col_s;
  logic [15:0]  rec_val_s;
  logic         unused_col_s;

  assign nnz_s        = row_ptr_s[135:128];
  assign rec_col_s    = rec_col(i_csr_rdata);
  assign rec_val_s    = rec_val(i_csr_rdata);
  assign unused_col_s = ^rec_col_s[REC_COL_W-1:XADDR_W];
  // A successor exists for the element the core is currently working on
  assign pf_s         = ({1'b0, count_q} + 9'd1) < {1'b0, nnz_s};
  assign ldr_start_s  = (state_q == ST_IDLE) && i_start;

`ifdef SPMV_FETCH_BOUNDS_EN
  logic mono_err_s, col_err_s, err_q;
  assign col_err_s = |(rec_col_s >> XADDR_W);

  // Abort conditions: bad row_ptr ordering, out-of-range column, runaway count
  always_comb begin
    bound_err_s = 1'b0;
    if (state_q == ST_PTR) begin
      bound_err_s = mono_err_s;
    end else if (state_q == ST_PRE_X) begin
      bound_err_s = col_err_s;
    end else if (state_q == ST_RUN) begin
      bound_err_s = ((i_core_state == CORE_ADD) && pf_s && col_err_s) || (count_q > nnz_s);
    end else begin
      bound_err_s = 1'b0;
    end
  end

  // Sticky error flag, cleared by the next accepted start
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)          err_q <= 1'b0;
    else if (ldr_start_s) err_q <= 1'b0;
    else if (bound_err_s) err_q <= 1'b1;
  end
  assign o_err = err_q;
`else
  assign bound_err_s = 1'b0;
`endif

  spmv_rowptr_loader #(
    .ADDR_W      (ADDR_W),
    .ROWPTR_BASE (ROWPTR_BASE)
  ) u_loader (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .start_i    (ldr_start_s),
    .abort_i    (bound_err_s),
    .rdata_i    (i_csr_rdata[7:0]),
    .rd_en_o    (ldr_en_s),
    .rd_addr_o  (ldr_addr_s),
    .last_o     (ldr_last_s),
    .row_ptr_o  (row_ptr_s)
`ifdef SPMV_FETCH_BOUNDS_EN
    ,
    .mono_err_o (mono_err_s)
`endif
  );

  // Fetch FSM next state; RUN tracks the core cadence to overlap the prefetch
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    stage_a_d     = stage_a_q;
    stage_b_d     = stage_b_q;
    stage_a_nxt_d = stage_a_nxt_q;
    seen_core_d   = seen_core_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_PTR;
          count_d = 8'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PTR: begin
        if (ldr_last_s) state_d = (i_csr_rdata[7:0] == 8'd0) ? ST_DONE : ST_PRE_NZ;
        else            state_d = ST_PTR;
      end
      ST_PRE_NZ: state_d = ST_PRE_X;
      ST_PRE_X: begin
        stage_a_d = rec_val_s;
        state_d   = ST_PRE_CAP;
      end
      ST_PRE_CAP: begin
        stage_b_d = i_x_rdata;
        state_d   = ST_KICK;
      end
      ST_KICK: begin
        if (i_core_state == CORE_IDLE) begin
          state_d     = ST_RUN;
          seen_core_d = 1'b0;
        end else begin
          state_d = ST_KICK;
        end
      end
      ST_RUN: begin
        if (i_core_state != CORE_IDLE) seen_core_d = 1'b1;
        else                           seen_core_d = seen_core_q;
        case (i_core_state)
          CORE_ADD: begin
            count_d = count_q + 8'd1;
            if (pf_s) stage_a_nxt_d = rec_val_s;
            else      stage_a_nxt_d = stage_a_nxt_q;
          end
          CORE_WRITE: begin
            // count_q is already incremented here, so this asks "was a successor fetched"
            if (count_q < nnz_s) begin
              stage_a_d = stage_a_nxt_q;
              stage_b_d = i_x_rdata;
            end else begin
              stage_a_d = stage_a_q;
              stage_b_d = stage_b_q;
            end
          end
          CORE_IDLE: begin
            if (seen_core_q) state_d = (count_q == nnz_s) ? ST_DONE : ST_KICK;
            else             state_d = ST_RUN;
          end
          default: state_d = ST_RUN;
        endcase
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (bound_err_s) state_d = ST_DONE;
    else             state_d = state_d;
  end

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q       <= ST_IDLE;
      count_q       <= 8'd0;
      stage_a_q     <= 16'd0;
      stage_b_q     <= 16'd0;
      stage_a_nxt_q <= 16'd0;
      seen_core_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      stage_a_q     <= stage_a_d;
      stage_b_q     <= stage_b_d;
      stage_a_nxt_q <= stage_a_nxt_d;
      seen_core_q   <= seen_core_d;
      busy_q        <= (state_d != ST_IDLE);
      done_q        <= (state_d == ST_DONE);
    end
  end

  // CSR port shared by the row_ptr loader, the initial prefetch and RUN prefetch
  always_comb begin
    o_csr_en   = 1'b0;
    o_csr_addr = {ADDR_W{1'b0}};
    if (ldr_en_s) begin
      o_csr_en   = 1'b1;
      o_csr_addr = ldr_addr_s;
    end else if (state_q == ST_PRE_NZ) begin
      o_csr_en   = 1'b1;
      o_csr_addr = ADDR_W'(NZ_BASE) + ADDR_W'(count_q);
    end else if ((state_q == ST_RUN) && (i_core_state == CORE_MUL) && pf_s) begin
      o_csr_en   = 1'b1;
      o_csr_addr = ADDR_W'(NZ_BASE) + ADDR_W'(count_q) + ADDR_W'(1);
    end else begin
      o_csr_en   = 1'b0;
      o_csr_addr = {ADDR_W{1'b0}};
    end
  end

  assign x_rd_s        = (state_q == ST_PRE_X) ||
                         ((state_q == ST_RUN) && (i_core_state == CORE_ADD) && pf_s);
  assign o_x_en        = x_rd_s;
  assign o_x_addr      = x_rd_s ? rec_col_s[XADDR_W-1:0] : {XADDR_W{1'b0}};
  assign o_core_start  = (state_q == ST_KICK) && (i_core_state == CORE_IDLE);
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_count       = count_q;
  assign o_row_ptr     = row_ptr_s;
  assign o_read_data_A = stage_a_q;
  assign o_read_data_B = stage_b_q;

endmodule

// File: tb/tb_spmv_csr_fetch.sv
// Directed bench for spmv_csr_fetch with behavioural CSR/x memories and a
// simple core model that walks LOAD->MUL->ADD->WRITE per nonzero.
module tb_spmv_csr_fetch;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         start = 1'b0;
  logic         o_busy, o_done, o_csr_en, o_x_en, o_core_start;
  logic [9:0]   o_csr_addr;
  logic [3:0]   o_x_addr;
  logic [23:0]  csr_rdata = 24'd0;
  logic [15:0]  x_rdata = 16'd0;
  logic [2:0]   core_st;
  logic [15:0]  o_a, o_b;
  logic [7:0]   o_count;
  logic [135:0] o_row_ptr;
`ifdef SPMV_FETCH_BOUNDS_EN
  logic         o_err;
`endif

  logic [23:0] csr_mem [0:1023];
  logic [15:0] x_mem   [0:15];
  logic [7:0]  rp      [0:16];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  spmv_csr_fetch dut (
    .i_clk         (clk),
    .i_rstn        (rstn),
    .i_start       (start),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_csr_en      (o_csr_en),
    .o_csr_addr    (o_csr_addr),
    .i_csr_rdata   (csr_rdata),
    .o_x_en        (o_x_en),
    .o_x_addr      (o_x_addr),
    .i_x_rdata     (x_rdata),
    .i_core_state  (core_st),
    .o_core_start  (o_core_start),
    .o_read_data_A (o_a),
    .o_read_data_B (o_b),
    .o_count       (o_count),
    .o_row_ptr     (o_row_ptr)
`ifdef SPMV_FETCH_BOUNDS_EN
    ,
    .o_err         (o_err)
`endif
  );

  // synchronous single-port memories
  always @(posedge clk) begin
    if (o_csr_en) csr_rdata <= csr_mem[o_csr_addr];
    if (o_x_en)   x_rdata   <= x_mem[o_x_addr];
  end

  // core: one nonzero per LOAD..WRITE, returns to IDLE at nnz or a 16-boundary
  always @(posedge clk or negedge rstn) begin
    if (!rstn) core_st <= 3'd0;
    else begin
      case (core_st)
        3'd0: core_st <= o_core_start ? 3'd1 : 3'd0;
        3'd1: core_st <= 3'd2;
        3'd2: core_st <= 3'd3;
        3'd3: core_st <= 3'd4;
        3'd4: core_st <= ((o_count == o_row_ptr[135:128]) || (o_count[3:0] == 4'd0)) ? 3'd0 : 3'd1;
        default: core_st <= 3'd0;
      endcase
    end
  end

  int mon_starts = 0, mon_dones = 0, mon_rd = 0, mon_viol = 0;
  logic [15:0] ld_a [$];
  logic [15:0] ld_b [$];
  logic [7:0]  ld_c [$];
  logic [7:0]  st_c [$];
  logic [15:0] prev_a = 16'd0, prev_b = 16'd0;
  logic [2:0]  prev_core = 3'd0;

  // observe handshakes and the prefetch cadence on the falling edge
  always @(negedge clk) begin
    if (rstn) begin
      if (o_core_start) begin
        mon_starts <= mon_starts + 1;
        st_c.push_back(o_count);
      end
      if (o_done)   mon_dones <= mon_dones + 1;
      if (o_csr_en) mon_rd    <= mon_rd + 1;
      if (core_st == 3'd1) begin
        ld_a.push_back(o_a);
        ld_b.push_back(o_b);
        ld_c.push_back(o_count);
      end
      mon_viol <= mon_viol
        + ((o_csr_en && (core_st == 3'd1 || core_st == 3'd3 || core_st == 3'd4)) ? 1 : 0)
        + ((o_x_en && (core_st == 3'd1 || core_st == 3'd2 || core_st == 3'd4)) ? 1 : 0)
        + ((({o_a, o_b} != {prev_a, prev_b}) && prev_core != 3'd4 && prev_core != 3'd0) ? 1 : 0);
    end
    prev_a    <= o_a;
    prev_b    <= o_b;
    prev_core <= core_st;
  end

  task automatic check(input string tag, input logic [135:0] act, input logic [135:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    rstn  = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic write_rowptr();
    for (int i = 0; i < 17; i++) csr_mem[i] = {16'h0000, rp[i]};
  endtask

  function automatic logic [135:0] rp_vec();
    logic [135:0] v;
    v = 136'd0;
    for (int i = 0; i < 17; i++) v[8*i +: 8] = rp[i];
    return v;
  endfunction

  task automatic run_job(input int max_cyc, output int lat, output logic got);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < max_cyc) begin
      @(negedge clk);
      lat++;
      if (o_done) got = 1'b1;
    end
    repeat (3) @(negedge clk);
  endtask

  logic [15:0] xid [0:3];
  int          lat, b_ld, b_st, b_dn, b_rd, b_vi, b_sc, c;
  logic        got;

  initial begin
    for (int i = 0; i < 1024; i++) csr_mem[i] = 24'd0;
    for (int i = 0; i < 16; i++)   x_mem[i]   = 16'hFFFF;
    do_reset();
    check("rst_busy", o_busy, 1'b0);
    check("rst_outputs", {o_done, o_csr_en, o_csr_addr, o_x_en, o_x_addr, o_core_start, o_a, o_b, o_count}, 59'd0);
    check("rst_row_ptr", o_row_ptr, 136'd0);

    // identity 4x4: val 1.0, x = fp16(i)
    xid[0] = 16'h0000; xid[1] = 16'h3C00; xid[2] = 16'h4000; xid[3] = 16'h4200;
    for (int i = 0; i < 17; i++) rp[i] = (i < 4) ? 8'(i) : 8'd4;
    write_rowptr();
    for (int k = 0; k < 4; k++) begin
      csr_mem[32+k] = {8'(k), 16'h3C00};
      x_mem[k]      = xid[k];
    end
    b_ld = ld_a.size(); b_st = mon_starts; b_dn = mon_dones; b_vi = mon_viol;
    run_job(500, lat, got);
    check("id_done_seen", got, 1'b1);
    check("id_loads", ld_a.size() - b_ld, 4);
    for (int k = 0; k < 4 && b_ld + k < ld_a.size(); k++) begin
      check($sformatf("id_A%0d", k), ld_a[b_ld+k], 16'h3C00);
      check($sformatf("id_B%0d", k), ld_b[b_ld+k], xid[k]);
      check($sformatf("id_cnt%0d", k), ld_c[b_ld+k], 8'(k));
    end
    check("id_starts", mon_starts - b_st, 1);
    check("id_dones", mon_dones - b_dn, 1);
    check("id_count", o_count, 8'd4);
    check("id_row_ptr", o_row_ptr, rp_vec());
    check("id_cadence", mon_viol - b_vi, 0);
    check("id_idle", o_busy, 1'b0);

    // nnz = 0: only the 17 row_ptr reads, done 18 cycles after the start edge
    for (int i = 0; i < 17; i++) rp[i] = 8'd0;
    write_rowptr();
    b_st = mon_starts; b_dn = mon_dones; b_rd = mon_rd;
    run_job(100, lat, got);
    check("z_done_seen", got, 1'b1);
    check("z_latency", lat, 18);
    check("z_csr_reads", mon_rd - b_rd, 17);
    check("z_starts", mon_starts - b_st, 0);
    check("z_dones", mon_dones - b_dn, 1);

    // nnz = 40 over three batches
    for (int i = 0; i < 17; i++) rp[i] = (i <= 13) ? 8'(3*i) : 8'd40;
    write_rowptr();
    for (int k = 0; k < 40; k++) csr_mem[32+k] = {8'((5*k+3) % 16), 16'h4000 + 16'(k)};
    for (int j = 0; j < 16; j++) x_mem[j] = 16'hB000 + 16'(j);
    b_ld = ld_a.size(); b_st = mon_starts; b_sc = st_c.size(); b_dn = mon_dones; b_vi = mon_viol;
    run_job(2000, lat, got);
    check("n40_done_seen", got, 1'b1);
    check("n40_starts", mon_starts - b_st, 3);
    for (int s = 0; s < 3 && b_sc + s < st_c.size(); s++)
      check($sformatf("n40_start_cnt%0d", s), st_c[b_sc+s], 8'(16*s));
    check("n40_loads", ld_a.size() - b_ld, 40);
    for (int k = 0; k < 40 && b_ld + k < ld_a.size(); k++) begin
      check($sformatf("n40_A%0d", k), ld_a[b_ld+k], 16'h4000 + 16'(k));
      check($sformatf("n40_B%0d", k), ld_b[b_ld+k], 16'hB000 + 16'((5*k+3) % 16));
    end
    check("n40_count", o_count, 8'd40);
    check("n40_dones", mon_dones - b_dn, 1);
    check("n40_row_ptr", o_row_ptr, rp_vec());
    check("n40_cadence", mon_viol - b_vi, 0);

    // reset in RUN at count 7, then a clean restart
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    c = 0;
    while (o_count != 8'd7 && c < 1000) begin
      @(negedge clk);
      c++;
    end
    check("mr_reach7", o_count, 8'd7);
    #2 rstn = 1'b0;
    #1;
    check("mr_outputs", {o_busy, o_done, o_csr_en, o_csr_addr, o_x_en, o_x_addr, o_core_start, o_a, o_b, o_count}, 60'd0);
    check("mr_row_ptr", o_row_ptr, 136'd0);
    @(negedge clk) rstn = 1'b1;
    @(negedge clk);
    b_ld = ld_a.size(); b_dn = mon_dones;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("mr_restart", {o_busy, o_count, o_csr_en, o_csr_addr}, {1'b1, 8'd0, 1'b1, 10'd0});
    c = 0;
    got = 1'b0;
    while (!got && c < 2000) begin
      @(negedge clk);
      c++;
      if (o_done) got = 1'b1;
    end
    repeat (3) @(negedge clk);
    check("mr_done_seen", got, 1'b1);
    check("mr_loads", ld_a.size() - b_ld, 40);
    check("mr_count", o_count, 8'd40);
    check("mr_dones", mon_dones - b_dn, 1);

`ifdef SPMV_FETCH_BOUNDS_EN
    // non-monotonic row_ptr aborts before the core is ever started
    for (int i = 0; i < 17; i++) rp[i] = 8'(2*i);
    rp[5] = 8'd9;
    rp[6] = 8'd8;
    write_rowptr();
    b_st = mon_starts; b_dn = mon_dones;
    run_job(200, lat, got);
    check("be_done_seen", got, 1'b1);
    check("be_err", o_err, 1'b1);
    check("be_starts", mon_starts - b_st, 0);
    check("be_dones", mon_dones - b_dn, 1);
    for (int i = 0; i < 17; i++) rp[i] = (i <= 13) ? 8'(3*i) : 8'd40;
    write_rowptr();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("be_err_clear", o_err, 1'b0);
    c = 0;
    while (!o_done && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check("be_ok_err", o_err, 1'b0);
    repeat (3) @(negedge clk);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
